// File: rtl/board_ram_arbiter_if.sv
// Bundles the CPU data port, video tile port and board RAM port seen by board_ram_arbiter.
// slave = arbiter side, master = the surrounding CPU/video/RAM side.
interface board_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              vid_req;
    logic [5:0]        vid_tile;
    logic              vid_gnt;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_rvalid;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_tile, ram_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid, vid_gnt, vid_rdata, vid_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_tile, ram_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid, vid_gnt, vid_rdata, vid_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/board_ram_arbiter.sv
// Shares the single-port board RAM between CPU LB/SB and VGA tile fetch; ARB_ROUND_ROBIN_EN selects alternating arbitration.
// Latency: grant is combinational, read data returns one cycle after the grant.
// Backpressure: CPU is stalled only when video wins; video waits at most MAX_STARVE+1 cycles.
module board_ram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int VID_BASE   = 64,
    parameter int MAX_STARVE = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    board_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    owner_t            rd_owner;
    logic              vid_pref;
    logic              vid_win;
    logic              cpu_win;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_vid;

    // Resets to VID so the first contended grant goes to the CPU.
    always_ff @(posedge CLK) begin
        if (RESET)        last_vid <= 1'b1;
        else if (vid_win) last_vid <= 1'b1;
        else if (cpu_win) last_vid <= 1'b0;
    end

    assign vid_pref = ~last_vid;
`else
    localparam int SW = $clog2(MAX_STARVE + 1);
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge CLK) begin
        if (RESET || !bus.vid_req || vid_win)
            starve_cnt <= '0;
        else if (starve_cnt != SW'(MAX_STARVE))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign vid_pref = (starve_cnt == SW'(MAX_STARVE));
`endif

    assign vid_win  = !RESET && bus.vid_req && (!bus.cpu_req || vid_pref);
    assign cpu_win  = !RESET && bus.cpu_req && !vid_win;
    assign vid_addr = ADDR_W'(VID_BASE) + {{(ADDR_W-6){1'b0}}, bus.vid_tile};

    always_comb begin
        bus.ram_en    = cpu_win | vid_win;
        bus.ram_we    = cpu_win & bus.cpu_we;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (vid_win) begin
            bus.ram_addr = vid_addr;
        end else if (cpu_win) begin
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
        end
        bus.cpu_stall = vid_win & bus.cpu_req;
        bus.vid_gnt   = vid_win;
    end

    // rd_owner steers the RAM's next-cycle data; held copies keep rdata stable between pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_owner    <= OWN_NONE;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            if (vid_win)                      rd_owner <= OWN_VID;
            else if (cpu_win && !bus.cpu_we)  rd_owner <= OWN_CPU;
            else                              rd_owner <= OWN_NONE;
            if (rd_owner == OWN_CPU) cpu_rdata_q <= bus.ram_rdata;
            if (rd_owner == OWN_VID) vid_rdata_q <= bus.ram_rdata;
        end
    end

    always_comb begin
        bus.cpu_rvalid = !RESET && (rd_owner == OWN_CPU);
        bus.vid_rvalid = !RESET && (rd_owner == OWN_VID);
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : cpu_rdata_q;
        bus.vid_rdata  = bus.vid_rvalid ? bus.ram_rdata : vid_rdata_q;
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Scoreboard bench for board_ram_arbiter with a behavioural 1-cycle RAM.
module tb_board_ram_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 8;
    localparam int VID_BASE = 64;
    localparam int MAX_ST   = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [DATA_W-1:0] mem     [1024];
    logic [DATA_W-1:0] ref_mem [1024];
    logic [DATA_W-1:0] cpu_q[$];
    logic [DATA_W-1:0] vid_q[$];

    board_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    board_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VID_BASE(VID_BASE), .MAX_STARVE(MAX_ST)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    // Pops expectations on each rvalid, pushes new ones from the reference memory on each grant.
    always @(negedge CLK) begin
        logic [ADDR_W-1:0] va;
        if (bus.cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_rvalid_unexp", bus.cpu_rvalid, 0);
            else                   check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
        end
        if (bus.vid_rvalid) begin
            if (vid_q.size() == 0) check("vid_rvalid_unexp", bus.vid_rvalid, 0);
            else                   check("vid_rdata", bus.vid_rdata, vid_q.pop_front());
        end
        if (!RESET && bus.cpu_req && !bus.cpu_stall) begin
            if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
            else            cpu_q.push_back(ref_mem[bus.cpu_addr]);
        end
        if (bus.vid_gnt) begin
            va = ADDR_W'(VID_BASE) + {4'b0, bus.vid_tile};
            vid_q.push_back(ref_mem[va]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic exp_vid(input int i);
`ifdef ARB_ROUND_ROBIN_EN
        return (i % 2) == 1;
`else
        return (i % (MAX_ST + 1)) == MAX_ST;
`endif
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        bus.ram_rdata = '0;
        RESET = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.vid_req = 0; bus.vid_tile = '0;

        tick(); tick();
        sample();
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_vid_gnt", bus.vid_gnt, 0);
        check("rst_cpu_stall", bus.cpu_stall, 0);
        check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        check("rst_vid_rvalid", bus.vid_rvalid, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_vid_rdata", bus.vid_rdata, 0);
        tick(); RESET = 1'b0;

        // CPU store then load of address 70
        tick(); bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 70; bus.cpu_wdata = 8'h5A;
        sample();
        check("t1_ram_en", bus.ram_en, 1);
        check("t1_ram_we", bus.ram_we, 1);
        check("t1_ram_addr", bus.ram_addr, 70);
        check("t1_st_stall", bus.cpu_stall, 0);
        tick(); bus.cpu_we = 0;
        sample();
        check("t1_ld_we", bus.ram_we, 0);
        check("t1_ld_stall", bus.cpu_stall, 0);
        check("t1_ld_rvalid_early", bus.cpu_rvalid, 0);
        tick(); bus.cpu_req = 0;
        sample();
        check("t1_rvalid", bus.cpu_rvalid, 1);
        check("t1_rdata", bus.cpu_rdata, 8'h5A);
        tick();
        sample();
        check("t1_rvalid_pulse", bus.cpu_rvalid, 0);
        check("t1_rdata_hold", bus.cpu_rdata, 8'h5A);

        // Video fetch of tile 6 after RAM[70] becomes 0x21
        tick(); bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 70; bus.cpu_wdata = 8'h21;
        sample();
        tick(); bus.cpu_req = 0; bus.cpu_we = 0; bus.vid_req = 1; bus.vid_tile = 6;
        sample();
        check("t2_vid_gnt", bus.vid_gnt, 1);
        check("t2_ram_addr", bus.ram_addr, 70);
        check("t2_ram_we", bus.ram_we, 0);
        tick(); bus.vid_req = 0;
        sample();
        check("t2_vid_rvalid", bus.vid_rvalid, 1);
        check("t2_vid_rdata", bus.vid_rdata, 8'h21);

        // Tile index wrap to the top of the display buffer
        tick(); bus.vid_req = 1; bus.vid_tile = 63;
        sample();
        check("t5_vid_gnt", bus.vid_gnt, 1);
        check("t5_ram_addr", bus.ram_addr, 127);
        tick(); bus.vid_req = 0;
        sample();
        check("t5_vid_rvalid", bus.vid_rvalid, 1);

        // Sustained contention
        tick(); bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5; bus.vid_req = 1; bus.vid_tile = 10;
        for (int i = 0; i < 10; i++) begin
            sample();
            check($sformatf("t3_vid_gnt_%0d", i), bus.vid_gnt, exp_vid(i));
            check($sformatf("t3_stall_%0d", i), bus.cpu_stall, exp_vid(i));
            check($sformatf("t3_addr_%0d", i), bus.ram_addr, exp_vid(i) ? 74 : 5);
            tick();
        end
        bus.cpu_req = 0; bus.vid_req = 0;
        sample();

        // Reset the cycle after a CPU read grant, requests still asserted
        tick(); bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 9; bus.vid_req = 1; bus.vid_tile = 3;
        sample();
        tick();
        sample();
        tick();
        sample();
        check("t4_pre_cpu_grant", bus.vid_gnt, 0);
        tick(); RESET = 1'b1;
        sample();
        check("t4_rst_cpu_rvalid", bus.cpu_rvalid, 0);
        check("t4_rst_ram_en", bus.ram_en, 0);
        check("t4_rst_vid_gnt", bus.vid_gnt, 0);
        check("t4_rst_stall", bus.cpu_stall, 0);
        tick(); RESET = 1'b0;
        cpu_q.delete();
        vid_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            sample();
            if (i == 0) begin
                check("t4_post_cpu_rvalid", bus.cpu_rvalid, 0);
                check("t4_post_vid_rvalid", bus.vid_rvalid, 0);
                check("t4_post_cpu_rdata", bus.cpu_rdata, 0);
                check("t4_post_vid_rdata", bus.vid_rdata, 0);
            end
            check($sformatf("t4_vid_gnt_%0d", i), bus.vid_gnt, exp_vid(i));
        end
        tick(); bus.cpu_req = 0; bus.vid_req = 0;
        sample();
        tick();
        sample();
        check("cpu_q_drained", cpu_q.size(), 0);
        check("vid_q_drained", vid_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
